// File: rtl/fir_tdm_filter_bank.sv
// Time-multiplexed FIR filter bank: NUM_BANDS filters of TAPS taps share one MAC and one
// circular sample delay line; coefficients are run-time writable registers.
module fir_tdm_filter_bank #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned COEF_W    = 12,
    parameter int unsigned TAPS      = 31,
    parameter int unsigned NUM_BANDS = 10,
    parameter int unsigned ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              enable,
    input  logic                                              sample_valid,
    output logic                                              sample_ready,
    input  logic signed [DATA_W-1:0]                          audio_in,
    input  logic                                              coef_we,
    output logic                                              coef_ready,
    input  logic [((NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1)-1:0] coef_band,
    input  logic [$clog2(TAPS)-1:0]                           coef_tap,
    input  logic signed [COEF_W-1:0]                          coef_data,
    output logic [NUM_BANDS*DATA_W-1:0]                       bands_out,
    output logic                                              out_valid,
    output logic                                              overrun,
    output logic [NUM_BANDS-1:0]                              sat_flag
);

    localparam int unsigned BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam int unsigned TAP_W  = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAPS - 1);
    localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);

    // Output range expressed at accumulator width; ~max is the most negative value.
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {StIdle, StRun, StStore, StDone} state_e;

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] dly_q   [TAPS];
    logic signed [COEF_W-1:0] coef_q  [NUM_BANDS][TAPS];
    logic signed [DATA_W-1:0] shadow_q[NUM_BANDS];
    logic [NUM_BANDS-1:0]     shadow_sat_q;

    logic [TAP_W-1:0]         wr_ptr_q, rd_ptr_q, tap_q;
    logic [BAND_W-1:0]        band_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic [NUM_BANDS*DATA_W-1:0] bands_q, bands_d;
    logic [NUM_BANDS-1:0]        sat_flag_q, sat_flag_d;
    logic                        overrun_q;

    logic                     accept, coef_wr, clip;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum, shifted;
    logic signed [DATA_W-1:0] sat_val;

    assign sample_ready = enable && (state_q == StIdle);
    assign coef_ready   = (state_q == StIdle);
    assign accept       = sample_valid && sample_ready;
    assign coef_wr      = coef_we && coef_ready
                          && (32'(coef_band) < NUM_BANDS) && (32'(coef_tap) < TAPS);

    assign bands_out = bands_q;
    assign sat_flag  = sat_flag_q;
    assign overrun   = overrun_q;
    assign out_valid = (state_q == StDone);

    // rd_ptr walks backwards from the newest sample, so tap t sees x[n-t].
    assign prod    = PROD_W'(coef_q[band_q][tap_q]) * PROD_W'(dly_q[rd_ptr_q]);
    assign acc_sum = acc_q + ACC_W'(prod);
    assign shifted = acc_q >>> (COEF_W - 1);

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        clip    = 1'b0;
        if (shifted > ACC_MAX) begin
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
            clip    = 1'b1;
        end else if (shifted < ACC_MIN) begin
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
            clip    = 1'b1;
        end
    end

    // Final band bypasses its shadow so the whole bus is published in one edge.
    always_comb begin
        bands_d    = bands_q;
        sat_flag_d = sat_flag_q;
        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
            bands_d[b*DATA_W +: DATA_W] = (b == 32'(band_q)) ? sat_val : shadow_q[b];
            sat_flag_d[b]               = (b == 32'(band_q)) ? clip : shadow_sat_q[b];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (tap_q == TAP_LAST) state_d = StStore;
            StStore: state_d = (band_q == BAND_LAST) ? StDone : StRun;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < TAPS; t++) begin
                dly_q[t] <= '0;
                for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                    coef_q[b][t] <= '0;
                end
            end
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                shadow_q[b] <= '0;
            end
            shadow_sat_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tap_q        <= '0;
            band_q       <= '0;
            acc_q        <= '0;
            bands_q      <= '0;
            sat_flag_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (coef_wr) begin
                coef_q[coef_band][coef_tap] <= coef_data;
            end
            if (sample_valid && !sample_ready) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        dly_q[wr_ptr_q] <= audio_in;
                        rd_ptr_q        <= wr_ptr_q;
                        wr_ptr_q        <= (wr_ptr_q == TAP_LAST) ? '0 : wr_ptr_q + TAP_W'(1);
                        acc_q           <= '0;
                        band_q          <= '0;
                        tap_q           <= '0;
                    end
                end
                StRun: begin
                    acc_q    <= acc_sum;
                    tap_q    <= (tap_q == TAP_LAST) ? '0 : tap_q + TAP_W'(1);
                    rd_ptr_q <= (rd_ptr_q == '0) ? TAP_LAST : rd_ptr_q - TAP_W'(1);
                end
                StStore: begin
                    shadow_q[band_q]     <= sat_val;
                    shadow_sat_q[band_q] <= clip;
                    acc_q                <= '0;
                    if (band_q == BAND_LAST) begin
                        bands_q    <= bands_d;
                        sat_flag_q <= sat_flag_d;
                    end else begin
                        band_q <= band_q + BAND_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_filter_bank.sv
// Directed bench for fir_tdm_filter_bank: vector table of samples with hand-computed band
// results, plus hand-written busy, enable, and mid-computation reset sequences.
module tb_fir_tdm_filter_bank;

    localparam int DW   = 24;
    localparam int CW   = 12;
    localparam int NT   = 31;
    localparam int NB   = 10;
    localparam int BW   = 4;
    localparam int TW   = 5;
    localparam int BUSW = NB * DW;
    localparam int LAT  = NB * (NT + 1) + 1;
    localparam int NVEC = 42;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b1;
    logic                 sample_valid = 1'b0;
    logic                 sample_ready;
    logic signed [DW-1:0] audio_in = '0;
    logic                 coef_we = 1'b0;
    logic                 coef_ready;
    logic [BW-1:0]        coef_band = '0;
    logic [TW-1:0]        coef_tap = '0;
    logic signed [CW-1:0] coef_data = '0;
    logic [BUSW-1:0]      bands_out;
    logic                 out_valid;
    logic                 overrun;
    logic [NB-1:0]        sat_flag;

    int checks = 0;
    int failures = 0;

    fir_tdm_filter_bank #(
        .DATA_W   (DW),
        .COEF_W   (CW),
        .TAPS     (NT),
        .NUM_BANDS(NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .audio_in    (audio_in),
        .coef_we     (coef_we),
        .coef_ready  (coef_ready),
        .coef_band   (coef_band),
        .coef_tap    (coef_tap),
        .coef_data   (coef_data),
        .bands_out   (bands_out),
        .out_valid   (out_valid),
        .overrun     (overrun),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic signed [DW-1:0] sample;
        logic [BUSW-1:0]      exp_bus;
        logic [NB-1:0]        exp_sat;
        int                   poke;   // 1: busy poke at cycle 5, 2: drop enable at cycle 10
    } vec_t;

    vec_t vecs[NVEC];

    function automatic logic [BUSW-1:0] mk(input logic signed [DW-1:0] b0,
                                           input logic signed [DW-1:0] b3,
                                           input logic signed [DW-1:0] b9);
        logic [BUSW-1:0] v;
        v = '0;
        v[0*DW +: DW] = b0;
        v[3*DW +: DW] = b3;
        v[9*DW +: DW] = b9;
        return v;
    endfunction

    task automatic chk(input string name, input logic [BUSW-1:0] got,
                       input logic [BUSW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic wr_coef(input int band, input int tap, input logic signed [CW-1:0] d);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_band = BW'(band);
        coef_tap  = TW'(tap);
        coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic apply(input string name, input logic signed [DW-1:0] smp,
                         input logic [BUSW-1:0] eb, input logic [NB-1:0] es, input int poke);
        int cyc;
        bit seen;
        logic [BUSW-1:0] held;
        @(negedge clk);
        chk({name, " ready"}, BUSW'(sample_ready), BUSW'(1));
        sample_valid = 1'b1;
        audio_in     = smp;
        @(negedge clk);
        sample_valid = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 1000) begin
            if (poke == 1 && cyc == 5) begin
                chk({name, " busy ready"}, BUSW'(sample_ready), BUSW'(0));
                chk({name, " busy coef_ready"}, BUSW'(coef_ready), BUSW'(0));
                sample_valid = 1'b1;
                audio_in     = 24'sh123456;
                coef_we      = 1'b1;
                coef_band    = BW'(3);
                coef_tap     = '0;
                coef_data    = '0;
            end
            if (poke == 1 && cyc == 6) begin
                sample_valid = 1'b0;
                coef_we      = 1'b0;
                chk({name, " overrun set"}, BUSW'(overrun), BUSW'(1));
            end
            if (poke == 2 && cyc == 10) enable = 1'b0;
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk({name, " out_valid seen"}, BUSW'(seen), BUSW'(1));
        chk({name, " latency"}, BUSW'(cyc), BUSW'(LAT));
        chk({name, " bands_out"}, bands_out, eb);
        chk({name, " sat_flag"}, BUSW'(sat_flag), BUSW'(es));
        held = bands_out;
        @(negedge clk);
        chk({name, " pulse width"}, BUSW'(out_valid), BUSW'(0));
        chk({name, " hold"}, bands_out, held);
    endtask

    localparam logic signed [DW-1:0] P = 24'sh7fffff;
    localparam logic signed [DW-1:0] N = 24'sh800000;

    initial begin
        int pulses;

        // Impulse through band 0: output j equals coefficient k=j, i.e. j+1, then zero.
        for (int j = 0; j < 32; j++) begin
            vecs[j].sample  = (j == 0) ? 24'sd2048 : 24'sd0;
            vecs[j].exp_bus = mk((j <= 30) ? DW'(j + 1) : '0, '0, '0);
            vecs[j].exp_sat = '0;
            vecs[j].poke    = 0;
        end
        vecs[32] = '{24'sd1000, mk('0, 24'sd999, '0), '0, 1};
        vecs[33] = '{-24'sd1000, mk('0, -24'sd1000, '0), '0, 0};
        // Band 9 sums 2047*sum(window)>>>11; the +/-1000 history cancels out.
        vecs[34] = '{P, mk('0, '0, 24'sd8384511), '0, 0};
        vecs[35] = '{P, mk('0, '0, P), 10'h200, 0};
        vecs[36] = '{P, mk('0, '0, P), 10'h200, 0};
        vecs[37] = '{N, mk('0, '0, P), 10'h200, 0};
        vecs[38] = '{N, mk('0, '0, 24'sd8384509), '0, 0};
        vecs[39] = '{N, mk('0, '0, -24'sd3), '0, 0};
        vecs[40] = '{N, mk('0, '0, -24'sd8384515), '0, 0};
        vecs[41] = '{N, mk('0, '0, N), 10'h200, 2};

        #12;
        chk("reset bands_out", bands_out, '0);
        chk("reset out_valid", BUSW'(out_valid), BUSW'(0));
        chk("reset overrun", BUSW'(overrun), BUSW'(0));
        chk("reset sat_flag", BUSW'(sat_flag), BUSW'(0));
        chk("reset coef_ready", BUSW'(coef_ready), BUSW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle sample_ready", BUSW'(sample_ready), BUSW'(1));

        wr_coef(10, 0, 12'sh7ff);  // out-of-range band, must be ignored
        for (int k = 0; k < NT; k++) wr_coef(0, k, CW'(k + 1));

        for (int i = 0; i < NVEC; i++) begin
            if (i == 32) begin
                chk("no overrun before poke", BUSW'(overrun), BUSW'(0));
                for (int k = 0; k < NT; k++) wr_coef(0, k, '0);
                wr_coef(3, 0, 12'sh7ff);
            end
            if (i == 34) begin
                chk("overrun sticky", BUSW'(overrun), BUSW'(1));
                wr_coef(3, 0, '0);
                for (int k = 0; k < NT; k++) wr_coef(9, k, 12'sh7ff);
            end
            apply($sformatf("vec%0d", i), vecs[i].sample, vecs[i].exp_bus, vecs[i].exp_sat,
                  vecs[i].poke);
        end

        chk("ready low with enable low", BUSW'(sample_ready), BUSW'(0));
        enable = 1'b1;

        // Reset at cycle 100 of a computation.
        @(negedge clk);
        sample_valid = 1'b1;
        audio_in     = 24'sd4321;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset bands_out", bands_out, '0);
        chk("midrun reset sat_flag", BUSW'(sat_flag), BUSW'(0));
        chk("midrun reset overrun", BUSW'(overrun), BUSW'(0));
        chk("midrun reset out_valid", BUSW'(out_valid), BUSW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("no out_valid after reset", BUSW'(pulses), BUSW'(0));

        // Sample held with enable low: never accepted, flags overrun.
        enable = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        audio_in     = 24'sd2048;
        chk("enable low ready", BUSW'(sample_ready), BUSW'(0));
        pulses = 0;
        repeat (340) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("enable low no accept", BUSW'(pulses), BUSW'(0));
        chk("enable low overrun", BUSW'(overrun), BUSW'(1));
        sample_valid = 1'b0;
        enable = 1'b1;

        // Coefficients were cleared by reset, so an impulse gives all-zero bands.
        apply("post-reset impulse", 24'sd2048, '0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
